eqn_sweep: RTL



---
 rtl/eqn_sweep_pkg.sv | 14 +
 rtl/eqn_tt_lookup.sv | 12 +
 rtl/eqn_sweep.sv | 104 ++++++++++
 3 files changed

// File: rtl/eqn_sweep_pkg.sv
// Shared types and constants for eqn_sweep: FSM state encoding, reset truth table, signature width.
package eqn_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Reset function Y = A&B | A&C over {A,B,C}
   localparam logic [7:0] TT_RESET_DEFAULT = 8'hE0;
   localparam int         SIG_W            = 8;

endpackage

// File: rtl/eqn_tt_lookup.sv
// Combinational truth-table lookup: selects one bit of an NMT-entry table by an N_IN-bit index.
module eqn_tt_lookup #(
   parameter int N_IN = 3
) (
   input  logic [2**N_IN-1:0] tt,
   input  logic [N_IN-1:0]    sel,
   output logic               value
);

   assign value = tt[sel];

endmodule

// File: rtl/eqn_sweep.sv
// Registered sum-of-products evaluator with a programmable truth table and exhaustive sweep engine.
// Optional macro EQN_SWEEP_SIG_EN adds an 8-bit rotating signature of the swept results.
module eqn_sweep
   import eqn_sweep_pkg::*;
#(
   parameter int                N_IN     = 3,
   parameter logic [2**N_IN-1:0] TT_RESET = (2**N_IN)'(TT_RESET_DEFAULT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_IN-1:0]      in_vec,
   input  logic                 tt_load,
   input  logic [2**N_IN-1:0]   tt_data,
   input  logic                 start,
   output logic                 y,
   output logic                 busy,
   output logic                 sweep_valid,
   output logic [N_IN-1:0]      sweep_vec,
   output logic                 sweep_y,
   output logic                 done,
`ifdef EQN_SWEEP_SIG_EN
   output logic [SIG_W-1:0]     sig,
`endif
   output logic [N_IN:0]        ones_count
);

   localparam int NMT = 2**N_IN;

   state_t            state;
   state_t            state_next;
   logic [N_IN-1:0]   cnt;
   logic [NMT-1:0]    tt;
   logic              live_bit;
   logic              sweep_bit;
   logic              accept;
   logic              last;

   eqn_tt_lookup #(.N_IN(N_IN)) u_live (
      .tt    (tt),
      .sel   (in_vec),
      .value (live_bit)
   );

   eqn_tt_lookup #(.N_IN(N_IN)) u_sweep (
      .tt    (tt),
      .sel   (cnt),
      .value (sweep_bit)
   );

   // A load in the same IDLE cycle as start takes priority and suppresses the sweep
   assign accept = (state == IDLE) && start && !tt_load;
   assign last   = (cnt == N_IN'(NMT - 1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SWEEP;
         SWEEP:   if (last)   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tt          <= TT_RESET;
         cnt         <= '0;
         y           <= 1'b0;
         sweep_valid <= 1'b0;
         sweep_vec   <= '0;
         sweep_y     <= 1'b0;
         ones_count  <= '0;
`ifdef EQN_SWEEP_SIG_EN
         sig         <= '0;
`endif
      end else begin
         state       <= state_next;
         y           <= live_bit;
         sweep_valid <= (state == SWEEP);
         if ((state == IDLE) && tt_load) tt <= tt_data;
         if (accept) begin
            cnt        <= '0;
            ones_count <= '0;
`ifdef EQN_SWEEP_SIG_EN
            sig        <= '0;
`endif
         end
         if (state == SWEEP) begin
            sweep_vec  <= cnt;
            sweep_y    <= sweep_bit;
            ones_count <= ones_count + {{N_IN{1'b0}}, sweep_bit};
            cnt        <= cnt + 1'b1;
`ifdef EQN_SWEEP_SIG_EN
            sig        <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ {{(SIG_W-1){1'b0}}, sweep_bit};
`endif
         end
      end
   end

   assign busy = (state == SWEEP);
   assign done = (state == DONE);

endmodule
